mem_exec_unit: RTL and testbench

//  Load/store execution stage directly downstream of the memory reservation station.

---
 rtl/mem_exec_unit.sv | 147 ++++++++++++++
 tb/tb_mem_exec_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_exec_unit.sv
// Load/store execution stage: one LD/STR in flight, 2**ADDR_W x DATA_W data memory, CDB broadcast.
// Latency: MEM_LAT cycles in ACCESS, then BCAST until granted; a STR then waits for its ROB commit.
// Backpressure: issue_ready only in IDLE; cdb_req held with stable outputs until cdb_grant; flush port under MEM_EXEC_FLUSH_EN.
module mem_exec_unit #(
    parameter int MEM_LAT = 2,
    parameter int DATA_W  = 3,
    parameter int ADDR_W  = 2,
    parameter int ROB_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_opcode,
    input  logic [DATA_W-1:0] issue_val,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [ROB_W-1:0]  cdb_rob_idx,
    output logic [DATA_W-1:0] cdb_val,
    output logic              cdb_is_store,
    input  logic              commit_en,
    input  logic [ROB_W-1:0]  commit_rob_idx,
`ifdef MEM_EXEC_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] OP_LD    = 3'b101;
    localparam logic [2:0] OP_STR   = 3'b110;
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        BCAST   = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                is_st_q, is_st_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ROB_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   cdb_val_q, cdb_val_d;
    logic                cdb_st_q, cdb_st_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic                flush_act;

`ifdef MEM_EXEC_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign issue_ready  = (state_q == IDLE);
    assign cdb_req      = (state_q == BCAST);
    assign cdb_rob_idx  = tag_q;
    assign cdb_val      = cdb_val_q;
    assign cdb_is_store = cdb_st_q;
    assign dbg_data     = mem_q[dbg_addr];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_st_d   = is_st_q;
        val_d     = val_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        cdb_val_d = cdb_val_q;
        cdb_st_d  = cdb_st_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid && (issue_opcode == OP_LD || issue_opcode == OP_STR)) begin
                    is_st_d = (issue_opcode == OP_STR);
                    val_d   = issue_val;
                    addr_d  = issue_addr;
                    tag_d   = issue_rob_idx;
                    cnt_d   = LAT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    cdb_val_d = is_st_q ? '0 : mem_q[addr_q];
                    cdb_st_d  = is_st_q;
                    state_d   = BCAST;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            BCAST: begin
                if (cdb_grant) begin
                    state_d = is_st_q ? ST_WAIT : IDLE;
                end
            end
            ST_WAIT: begin
                if (commit_en && commit_rob_idx == tag_q) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush outranks commit: a held store is dropped without touching memory.
        if (flush_act) begin
            state_d = IDLE;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_st_q   <= 1'b0;
            val_q     <= '0;
            addr_q    <= '0;
            tag_q     <= '0;
            cdb_val_q <= '0;
            cdb_st_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_st_q   <= is_st_d;
            val_q     <= val_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            cdb_val_q <= cdb_val_d;
            cdb_st_q  <= cdb_st_d;
            if (mem_we) begin
                mem_q[addr_q] <= val_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed bench for mem_exec_unit (MEM_LAT=2); flush cases build only with MEM_EXEC_FLUSH_EN.
module tb_mem_exec_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_opcode;
    logic [2:0] issue_val;
    logic [1:0] issue_addr;
    logic [1:0] issue_rob_idx;
    logic       cdb_req;
    logic       cdb_grant;
    logic [1:0] cdb_rob_idx;
    logic [2:0] cdb_val;
    logic       cdb_is_store;
    logic       commit_en;
    logic [1:0] commit_rob_idx;
    logic       flush;
    logic [1:0] dbg_addr;
    logic [2:0] dbg_data;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] LD  = 3'b101;
    localparam logic [2:0] STR = 3'b110;

    always #5 clk = ~clk;

    mem_exec_unit #(.MEM_LAT(2), .DATA_W(3), .ADDR_W(2), .ROB_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_opcode   (issue_opcode),
        .issue_val      (issue_val),
        .issue_addr     (issue_addr),
        .issue_rob_idx  (issue_rob_idx),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .cdb_rob_idx    (cdb_rob_idx),
        .cdb_val        (cdb_val),
        .cdb_is_store   (cdb_is_store),
        .commit_en      (commit_en),
        .commit_rob_idx (commit_rob_idx),
`ifdef MEM_EXEC_FLUSH_EN
        .flush          (flush),
`endif
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] v, input logic [1:0] a, input logic [1:0] t);
        issue_valid   = 1'b1;
        issue_opcode  = op;
        issue_val     = v;
        issue_addr    = a;
        issue_rob_idx = t;
        tick();
        issue_valid   = 1'b0;
    endtask

    task automatic commit(input logic [1:0] t);
        commit_en      = 1'b1;
        commit_rob_idx = t;
        tick();
        commit_en      = 1'b0;
    endtask

    task automatic mem_is(input string tag, input logic [1:0] a, input logic [2:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_opcode = 3'b0; issue_val = 3'b0;
        issue_addr = 2'b0; issue_rob_idx = 2'b0; cdb_grant = 1'b0; commit_en = 1'b0;
        commit_rob_idx = 2'b0; flush = 1'b0; dbg_addr = 2'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: reset state
        for (int i = 0; i < 4; i++) mem_is($sformatf("rst_mem%0d", i), 2'(i), 3'd0);
        chk("rst_ready",  32'(issue_ready),  32'd1);
        chk("rst_req",    32'(cdb_req),      32'd0);
        chk("rst_tag",    32'(cdb_rob_idx),  32'd0);
        chk("rst_val",    32'(cdb_val),      32'd0);
        chk("rst_is_st",  32'(cdb_is_store), 32'd0);

        // illegal opcode stays in IDLE
        issue(3'b000, 3'd1, 2'd1, 2'd1);
        chk("badop_ready", 32'(issue_ready), 32'd1);
        tick(); tick();
        chk("badop_req",   32'(cdb_req),     32'd0);

        // 2: STR val=5 addr=2 tag=1, grant held high
        cdb_grant = 1'b1;
        issue(STR, 3'd5, 2'd2, 2'd1);
        chk("st_busy",    32'(issue_ready),  32'd0);
        chk("st_req_a1",  32'(cdb_req),      32'd0);
        tick();
        chk("st_req_a2",  32'(cdb_req),      32'd0);
        tick();
        chk("st_req",     32'(cdb_req),      32'd1);
        chk("st_is_st",   32'(cdb_is_store), 32'd1);
        chk("st_tag",     32'(cdb_rob_idx),  32'd1);
        chk("st_val",     32'(cdb_val),      32'd0);
        tick();
        chk("st_req_drop", 32'(cdb_req),     32'd0);
        chk("st_wait_busy", 32'(issue_ready), 32'd0);
        mem_is("st_precommit", 2'd2, 3'd0);
        commit(2'd1);
        mem_is("st_commit", 2'd2, 3'd5);
        chk("st_done_ready", 32'(issue_ready), 32'd1);

        // 3: LD addr=2 tag=3 sees the committed store
        issue(LD, 3'd0, 2'd2, 2'd3);
        tick(); tick();
        chk("ld_req",     32'(cdb_req),      32'd1);
        chk("ld_val",     32'(cdb_val),      32'd5);
        chk("ld_tag",     32'(cdb_rob_idx),  32'd3);
        chk("ld_is_st",   32'(cdb_is_store), 32'd0);
        tick();
        chk("ld_ready",   32'(issue_ready),  32'd1);
        chk("ld_req_drop", 32'(cdb_req),     32'd0);

        // 4: grant withheld; issue while busy ignored
        cdb_grant = 1'b0;
        issue(LD, 3'd0, 2'd2, 2'd2);
        tick(); tick();
        issue_valid = 1'b1; issue_opcode = STR; issue_val = 3'd7; issue_addr = 2'd1; issue_rob_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_req%0d", i), 32'(cdb_req),     32'd1);
            chk($sformatf("hold_tag%0d", i), 32'(cdb_rob_idx), 32'd2);
            chk($sformatf("hold_val%0d", i), 32'(cdb_val),     32'd5);
            tick();
        end
        issue_valid = 1'b0;
        cdb_grant = 1'b1;
        tick();
        chk("hold_ready", 32'(issue_ready), 32'd1);
        chk("hold_drop",  32'(cdb_req),     32'd0);
        tick(); tick(); tick();
        chk("busy_issue_ignored", 32'(cdb_req), 32'd0);
        mem_is("busy_mem1", 2'd1, 3'd0);

        // 5: commit tag matching
        issue(STR, 3'd3, 2'd0, 2'd0);
        tick(); tick(); tick();
        commit(2'd2);
        mem_is("badtag_mem", 2'd0, 3'd0);
        chk("badtag_busy", 32'(issue_ready), 32'd0);
        commit(2'd0);
        mem_is("goodtag_mem", 2'd0, 3'd3);
        chk("goodtag_ready", 32'(issue_ready), 32'd1);
        commit(2'd0);
        chk("idle_commit_ready", 32'(issue_ready), 32'd1);
        chk("idle_commit_req",   32'(cdb_req),     32'd0);
        mem_is("idle_commit_mem", 2'd0, 3'd3);

`ifdef MEM_EXEC_FLUSH_EN
        // 6: flush in ST_WAIT and in BCAST
        issue(STR, 3'd6, 2'd3, 2'd1);
        tick(); tick(); tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fl_st_ready", 32'(issue_ready), 32'd1);
        commit(2'd1);
        mem_is("fl_st_mem", 2'd3, 3'd0);
        cdb_grant = 1'b0;
        issue(LD, 3'd0, 2'd0, 2'd2);
        tick(); tick();
        chk("fl_bc_req", 32'(cdb_req), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fl_bc_drop",  32'(cdb_req),     32'd0);
        chk("fl_bc_ready", 32'(issue_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
